axi_rd_burst_arbiter: RTL and testbench
=======================================

// Module: axi_rd_burst_arbiter
// PURPOSE
//  Shares one AXI4 full-burst read engine between NUM_CH video readout channels in the stitching path.
//  Each channel is a FIFO-to-video controller raising a burst request per line or VS edge.
//  - Round-robin grant; the granted channel owns the engine until its last beat.
//  - Read beats are demuxed to the owner's FIFO write enable.
//  - Address, length and ownership errors are flagged.
// PARAMETERS
//  NUM_CH      2     number of requesting channels (2..4)
//  ADDR_WIDTH  32    byte address width of a burst request
//  BURST_LEN   16    expected beats per burst (AXI4_DATA_WIDTH-wide beats)
//  WDT_CYCLES  4096  watchdog limit in clocks (used only with ARB_WATCHDOG_EN)
// PORTS
//  M_AXI_ACLK     in   1                clock, single domain
//  M_AXI_ARESETN  in   1                asynchronous active-low reset
//  s_burst_valid  in   NUM_CH           per-channel burst request, held until accepted
//  s_burst_addr   in   NUM_CH*ADDR_WIDTH per-channel start address, ch0 in LSBs
//  s_burst_ready  out  NUM_CH           one-hot acceptance, combinational
//  m_burst_valid  out  1                request to the read engine
//  m_burst_ready  in   1                engine accepts the request
//  m_burst_addr   out  ADDR_WIDTH       latched address of the granted channel
//  m_burst_ch     out  clog2(NUM_CH)    owner id, valid from acceptance to last beat
//  m_rdata_valid  in   1                read beat strobe from the engine
//  m_rlast        in   1                last beat of the current burst
//  ch_wr_en       out  NUM_CH           demuxed beat strobe to the owner channel's FIFO
//  arb_busy       out  1                high in ISSUE and BUSY
//  len_err        out  1                sticky; last beat arrived with beat count != BURST_LEN
//  timeout_err    out  1                sticky watchdog flag; tied 0 without ARB_WATCHDOG_EN
// BEHAVIOUR
//  - Reset (async): state=IDLE, rr_ptr=0, and the beat counter is cleared.
//    All registered outputs are 0, including m_burst_ch, m_burst_addr, len_err and timeout_err.
//  - FSM states: IDLE, ISSUE, BUSY.
//  - IDLE:
//    - grant = first asserted s_burst_valid, scanning from rr_ptr upward with wrap at NUM_CH.
//    - s_burst_ready = onehot(grant) when in IDLE and any valid is high; else 0 (zero-latency accept).
//    - On accept: latch addr and channel id, then go to ISSUE on the next edge.
//  - ISSUE:
//    - m_burst_valid=1, held stable until m_burst_ready is sampled high.
//    - Then go to BUSY and clear the beat counter.
//  - BUSY:
//    - ch_wr_en[owner] = m_rdata_valid, combinational; other bits 0.
//    - Each beat increments the beat counter.
//    - On m_rdata_valid & m_rlast: set len_err if count+1 != BURST_LEN, go to IDLE, rr_ptr = owner+1 (mod NUM_CH).
//  - m_rdata_valid outside BUSY is ignored: no ch_wr_en, no count.
//  - Requests arriving in ISSUE or BUSY wait, since the requester holds valid.
//    A released owner gets lowest priority next round.
//  - Grant is re-evaluated only in IDLE; a request dropped before acceptance is simply not granted.
//  - Reset mid-burst: immediate return to IDLE with outputs cleared; beats after reset are discarded.
//  - Minimum turnaround: last beat to next accept is 1 clock (the IDLE cycle).
// CONFIGURATION
//  ARB_WATCHDOG_EN defined:
//    - A counter runs in ISSUE and BUSY and clears on each state entry or beat.
//    - On reaching WDT_CYCLES: set timeout_err, force IDLE, rr_ptr = owner+1.
//  ARB_WATCHDOG_EN undefined: no counter is built; timeout_err is a constant 0; the FSM waits indefinitely.
// STRUCTURE
//  - Shared package video_ddr_pkg: arb_state_t enum {IDLE, ISSUE, BUSY}, CH_ID_W = $clog2(NUM_CH), the BEAT_CNT_W constant.
//  - Sub-module rr_grant_sel: combinational rotate-priority-rotate-back one-hot picker (inputs req and ptr; outputs grant and grant_id).
// TESTING
//  - Reset, then ch0 valid with addr 0x1000: s_burst_ready[0] high same cycle.
//    m_burst_valid next cycle with addr 0x1000 and ch 0; 16 beats give ch_wr_en[0] x16; len_err=0.
//  - ch0 and ch1 both valid continuously: grants alternate 0,1,0,1.
//    No grant issued while arb_busy; ch_wr_en never hits a non-owner.
//  - m_burst_ready held low 10 cycles: m_burst_valid and m_burst_addr stable throughout, state stays ISSUE.
//  - m_rlast on beat 12 of 16: len_err=1 and stays set; FSM returns to IDLE.
//  - Reset asserted after beat 5: outputs 0 asynchronously; remaining beats produce no ch_wr_en.
//  - ARB_WATCHDOG_EN with WDT_CYCLES=64, m_burst_ready never high: timeout_err=1 after 64 clocks.
//    Next accept goes to ch1 when both channels request.

Source files
------------

// File: rtl/axi_rd_burst_arbiter_pkg.sv
// Shared types and constants for the video DDR read path: arbiter FSM states,
// beat counter width and the channel-id width helper.
package video_ddr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  // Wide enough for BURST_LEN up to 255; the counter saturates beyond that.
  localparam int unsigned BEAT_CNT_W = 8;

  // CH_ID_W = $clog2(NUM_CH), but never narrower than one bit.
  function automatic int unsigned ch_id_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/axi_rd_burst_arbiter_if.sv
// Bus bundle between the video readout channels, the arbiter and the AXI4
// read engine. The master modport is the arbiter's view; the slave modport
// is the environment (channels plus engine) facing it.
interface axi_rd_burst_arbiter_if
  import video_ddr_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned CH_ID_W = ch_id_w(NUM_CH);

  logic [NUM_CH-1:0]            s_burst_valid;
  logic [NUM_CH*ADDR_WIDTH-1:0] s_burst_addr;
  logic [NUM_CH-1:0]            s_burst_ready;
  logic                         m_burst_valid;
  logic                         m_burst_ready;
  logic [ADDR_WIDTH-1:0]        m_burst_addr;
  logic [CH_ID_W-1:0]           m_burst_ch;
  logic                         m_rdata_valid;
  logic                         m_rlast;
  logic [NUM_CH-1:0]            ch_wr_en;
  logic                         arb_busy;
  logic                         len_err;
  logic                         timeout_err;

  modport master (
    input  s_burst_valid, s_burst_addr, m_burst_ready, m_rdata_valid, m_rlast,
    output s_burst_ready, m_burst_valid, m_burst_addr, m_burst_ch, ch_wr_en,
           arb_busy, len_err, timeout_err
  );

  modport slave (
    output s_burst_valid, s_burst_addr, m_burst_ready, m_rdata_valid, m_rlast,
    input  s_burst_ready, m_burst_valid, m_burst_addr, m_burst_ch, ch_wr_en,
           arb_busy, len_err, timeout_err
  );

endinterface

// File: rtl/axi_rd_burst_arbiter_rr_grant_sel.sv
// Round-robin one-hot picker: rotate the request vector so that ptr sits at
// bit 0, take the lowest set bit, then rotate the index back.
module rr_grant_sel #(
  parameter int unsigned N    = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [N-1:0] rot_req;

  // Rotate, priority-pick (lowest index wins), rotate back.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rot_req  = '0;
    grant    = '0;
    grant_id = '0;
    for (int i = 0; i < N; i++) begin
      rot_req[i] = req[(i + int'(ptr)) % N];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_req[i]) grant_id = ID_W'((i + int'(ptr)) % N);
    end
    if (|req) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/axi_rd_burst_arbiter.sv
// Round-robin arbiter sharing one AXI4 burst read engine between NUM_CH
// video readout channels. The owner keeps the engine until its last beat;
// beats are demuxed to the owner's FIFO write enable.
// Optional watchdog: define ARB_WATCHDOG_EN to build the stall counter.
module axi_rd_burst_arbiter
  import video_ddr_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16
`ifdef ARB_WATCHDOG_EN
  ,
  parameter int unsigned WDT_CYCLES = 4096
`endif
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  axi_rd_burst_arbiter_if.master bus
);

  localparam int unsigned CH_ID_W = ch_id_w(NUM_CH);

  arb_state_t              state_q, state_d;
  logic [CH_ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CH_ID_W-1:0]      ch_q, ch_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
  logic                    len_err_q, len_err_d;
  logic                    timeout_q, timeout_d;
  logic [NUM_CH-1:0]       grant;
  logic [CH_ID_W-1:0]      grant_id;
  logic [NUM_CH-1:0]       s_ready;
  logic [NUM_CH-1:0]       wr_en;
  logic [CH_ID_W-1:0]      next_ptr;

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
`endif

  rr_grant_sel #(.N(NUM_CH), .ID_W(CH_ID_W)) u_sel (
    .req      (bus.s_burst_valid),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // The released owner drops to lowest priority for the next round.
  assign next_ptr = (ch_q == CH_ID_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

  // Next-state, acceptance, beat demux and error flags.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    len_err_d = len_err_q;
    timeout_d = timeout_q;
    s_ready   = '0;
    wr_en     = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.s_burst_valid) begin
          s_ready = grant;
          addr_d  = bus.s_burst_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
          ch_d    = grant_id;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_burst_ready) begin
          state_d = BUSY;
          beat_d  = '0;
        end
      end
      BUSY: begin
        if (bus.m_rdata_valid) begin
          wr_en[ch_q] = 1'b1;
          if (beat_q != '1) beat_d = beat_q + 1'b1;
          if (bus.m_rlast) begin
            if ((32'(beat_q) + 32'd1) != 32'(BURST_LEN)) len_err_d = 1'b1;
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef ARB_WATCHDOG_EN
    // Stall counter: cleared on every state entry or beat, aborts the owner on expiry.
    wdt_d = '0;
    if ((state_q == ISSUE || state_q == BUSY) && state_d == state_q &&
        !(state_q == BUSY && bus.m_rdata_valid)) begin
      if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        state_d   = IDLE;
        rr_ptr_d  = next_ptr;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
`endif
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      ch_q      <= '0;
      addr_q    <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      len_err_q <= len_err_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  // Watchdog counter register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) wdt_q <= '0;
    else                wdt_q <= wdt_d;
  end
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.s_burst_ready = s_ready;
  assign bus.ch_wr_en      = wr_en;
  assign bus.m_burst_valid = (state_q == ISSUE);
  assign bus.arb_busy      = (state_q != IDLE);
  assign bus.m_burst_addr  = addr_q;
  assign bus.m_burst_ch    = ch_q;
  assign bus.len_err       = len_err_q;

endmodule

// File: tb/tb_axi_rd_burst_arbiter.sv
// Directed bench for axi_rd_burst_arbiter (NUM_CH=2, BURST_LEN=16): a table of
// bursts with hand-computed grants, plus sequences for issue stall, reset
// mid-burst and (with ARB_WATCHDOG_EN) the watchdog.
module tb_axi_rd_burst_arbiter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  axi_rd_burst_arbiter_if #(.NUM_CH(2), .ADDR_WIDTH(32)) bus ();

  axi_rd_burst_arbiter #(
    .NUM_CH(2), .ADDR_WIDTH(32), .BURST_LEN(16)
`ifdef ARB_WATCHDOG_EN
    , .WDT_CYCLES(64)
`endif
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .bus           (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] addr0;
    logic [31:0] addr1;
    int          rlast_at;
    int          exp_ch;
    logic [31:0] exp_addr;
    logic        exp_len_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives n beats starting at a negedge; returns at the negedge after the last one.
  task automatic run_beats(input int n, input int last_at, input logic [1:0] exp_en, input string tag);
    for (int b = 1; b <= n; b++) begin
      bus.m_rdata_valid = 1'b1;
      bus.m_rlast       = (b == last_at);
      #1;
      check($sformatf("%s beat%0d wr_en", tag, b), 64'(bus.ch_wr_en), 64'(exp_en));
      check($sformatf("%s beat%0d ready", tag, b), 64'(bus.s_burst_ready), 64'd0);
      @(negedge clk);
    end
    bus.m_rdata_valid = 1'b0;
    bus.m_rlast       = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_g;

    //            valid  addr0         addr1         last exp_ch exp_addr      len_err
    vecs[0] = '{2'b01, 32'h0000_1000, 32'h0000_2000, 16, 0, 32'h0000_1000, 1'b0};
    vecs[1] = '{2'b11, 32'h0000_1100, 32'h0000_2100, 16, 1, 32'h0000_2100, 1'b0};
    vecs[2] = '{2'b11, 32'h0000_1200, 32'h0000_2200, 16, 0, 32'h0000_1200, 1'b0};
    vecs[3] = '{2'b11, 32'h0000_1300, 32'h0000_2300, 16, 1, 32'h0000_2300, 1'b0};
    vecs[4] = '{2'b10, 32'h0000_1400, 32'h0000_2400, 16, 1, 32'h0000_2400, 1'b0};
    vecs[5] = '{2'b01, 32'h0000_1500, 32'h0000_2500, 16, 0, 32'h0000_1500, 1'b0};
    vecs[6] = '{2'b01, 32'h0000_1600, 32'h0000_2600, 16, 0, 32'h0000_1600, 1'b0};
    vecs[7] = '{2'b11, 32'h0000_1700, 32'h0000_2700, 12, 1, 32'h0000_2700, 1'b1};

    bus.s_burst_valid = '0;
    bus.s_burst_addr  = '0;
    bus.m_burst_ready = 1'b0;
    bus.m_rdata_valid = 1'b0;
    bus.m_rlast       = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state; a stray beat in IDLE must not reach any FIFO.
    @(negedge clk);
    bus.m_rdata_valid = 1'b1;
    #1;
    check("rst m_burst_valid", 64'(bus.m_burst_valid), 64'd0);
    check("rst m_burst_addr", 64'(bus.m_burst_addr), 64'd0);
    check("rst m_burst_ch", 64'(bus.m_burst_ch), 64'd0);
    check("rst arb_busy", 64'(bus.arb_busy), 64'd0);
    check("rst len_err", 64'(bus.len_err), 64'd0);
    check("rst timeout_err", 64'(bus.timeout_err), 64'd0);
    check("rst wr_en", 64'(bus.ch_wr_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle stray beat wr_en", 64'(bus.ch_wr_en), 64'd0);
    @(negedge clk);
    bus.m_rdata_valid = 1'b0;

    // Table of bursts: accept, issue, beats, return to IDLE.
    for (int i = 0; i < 8; i++) begin
      exp_g = (vecs[i].exp_ch == 1) ? 2'b10 : 2'b01;
      bus.s_burst_addr  = {vecs[i].addr1, vecs[i].addr0};
      bus.s_burst_valid = vecs[i].valid;
      #1;
      check($sformatf("v%0d accept ready", i), 64'(bus.s_burst_ready), 64'(exp_g));
      check($sformatf("v%0d idle busy", i), 64'(bus.arb_busy), 64'd0);
      @(negedge clk);
      bus.s_burst_valid = vecs[i].valid & ~exp_g;
      #1;
      check($sformatf("v%0d issue ready", i), 64'(bus.s_burst_ready), 64'd0);
      check($sformatf("v%0d m_burst_valid", i), 64'(bus.m_burst_valid), 64'd1);
      check($sformatf("v%0d m_burst_addr", i), 64'(bus.m_burst_addr), 64'(vecs[i].exp_addr));
      check($sformatf("v%0d m_burst_ch", i), 64'(bus.m_burst_ch), 64'(vecs[i].exp_ch));
      check($sformatf("v%0d issue busy", i), 64'(bus.arb_busy), 64'd1);
      bus.m_burst_ready = 1'b1;
      @(negedge clk);
      bus.m_burst_ready = 1'b0;
      check($sformatf("v%0d busy m_burst_valid", i), 64'(bus.m_burst_valid), 64'd0);
      run_beats(vecs[i].rlast_at, vecs[i].rlast_at, exp_g, $sformatf("v%0d", i));
      bus.s_burst_valid = '0;
      #1;
      check($sformatf("v%0d done busy", i), 64'(bus.arb_busy), 64'd0);
      check($sformatf("v%0d len_err", i), 64'(bus.len_err), 64'(vecs[i].exp_len_err));
      check($sformatf("v%0d timeout_err", i), 64'(bus.timeout_err), 64'd0);
    end

    // Engine holds m_burst_ready low for 10 cycles; len_err stays sticky.
    bus.s_burst_addr  = {32'h0000_5000, 32'h0000_3000};
    bus.s_burst_valid = 2'b01;
    #1;
    check("stall accept ready", 64'(bus.s_burst_ready), 64'h1);
    @(negedge clk);
    bus.s_burst_valid = '0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("stall%0d m_burst_valid", k), 64'(bus.m_burst_valid), 64'd1);
      check($sformatf("stall%0d m_burst_addr", k), 64'(bus.m_burst_addr), 64'h3000);
      check($sformatf("stall%0d busy", k), 64'(bus.arb_busy), 64'd1);
      @(negedge clk);
    end
    bus.m_burst_ready = 1'b1;
    @(negedge clk);
    bus.m_burst_ready = 1'b0;
    run_beats(16, 16, 2'b01, "stall");
    #1;
    check("stall len_err sticky", 64'(bus.len_err), 64'd1);
    check("stall done busy", 64'(bus.arb_busy), 64'd0);

    // Reset after beat 5 of a ch1 burst; the rest of the beats are discarded.
    bus.s_burst_addr  = {32'h0000_4000, 32'h0000_6000};
    bus.s_burst_valid = 2'b10;
    #1;
    check("rstmid accept ready", 64'(bus.s_burst_ready), 64'h2);
    @(negedge clk);
    bus.s_burst_valid = '0;
    bus.m_burst_ready = 1'b1;
    @(negedge clk);
    bus.m_burst_ready = 1'b0;
    run_beats(5, 0, 2'b10, "rstmid");
    bus.m_rdata_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rstmid async wr_en", 64'(bus.ch_wr_en), 64'd0);
    check("rstmid async busy", 64'(bus.arb_busy), 64'd0);
    check("rstmid async addr", 64'(bus.m_burst_addr), 64'd0);
    check("rstmid async len_err", 64'(bus.len_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_beats(11, 11, 2'b00, "post_rst");
    #1;
    check("post_rst busy", 64'(bus.arb_busy), 64'd0);
    check("post_rst len_err", 64'(bus.len_err), 64'd0);

`ifdef ARB_WATCHDOG_EN
    // Engine never accepts: watchdog fires after 64 clocks in ISSUE, then ch1 wins.
    @(negedge clk);
    bus.s_burst_addr  = {32'h0000_2800, 32'h0000_1800};
    bus.s_burst_valid = 2'b11;
    #1;
    check("wdt accept ready", 64'(bus.s_burst_ready), 64'h1);
    @(negedge clk);
    bus.s_burst_valid = 2'b10;
    repeat (63) @(negedge clk);
    #1;
    check("wdt before expiry", 64'(bus.timeout_err), 64'd0);
    check("wdt before busy", 64'(bus.arb_busy), 64'd1);
    @(negedge clk);
    bus.s_burst_valid = 2'b11;
    #1;
    check("wdt timeout_err", 64'(bus.timeout_err), 64'd1);
    check("wdt ready ch1", 64'(bus.s_burst_ready), 64'h2);
    @(negedge clk);
    bus.s_burst_valid = '0;
    #1;
    check("wdt regrant ch", 64'(bus.m_burst_ch), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
